// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that shares one main-memory block port between the D-cache (port 0)
// and the I-cache (port 1), holding the bus for a fixed latency per 16-byte block transfer.
module cache_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         we0,
  input  logic [9:0]   addr0,
  input  logic [127:0] wdata0,
  input  logic         req1,
  input  logic         we1,
  input  logic [9:0]   addr1,
  input  logic [127:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [127:0] rdata,
  output logic         mem_write,
  output logic [9:0]   address_mem,
  output logic [127:0] data_write2mem,
  input  logic [127:0] data_read4cache
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [9:0]    addr_q, addr_d;
  logic [127:0]  wdata_q, wdata_d;
  logic [127:0]  rdata_q, rdata_d;
  logic          sel;

  // Byte offset within a block never reaches memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[3:0], addr1[3:0]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel     = (req0 && req1) ? ptr_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = sel;
          we_d    = sel ? we1 : we0;
          addr_d  = {(sel ? addr1[9:4] : addr0[9:4]), 4'b0000};
          wdata_d = sel ? wdata1 : wdata0;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) rdata_d = data_read4cache;
          state_d = DONE;
        end
      end
      DONE: begin
        // Hand priority to the port that was not just served.
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 10'd0;
      wdata_q <= 128'd0;
      rdata_q <= 128'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack0           = (state_q == DONE) && !gnt_q;
  assign ack1           = (state_q == DONE) && gnt_q;
  assign mem_write      = (state_q == ACCESS) && we_q;
  assign address_mem    = addr_q;
  assign data_write2mem = wdata_q;
  assign rdata          = rdata_q;

endmodule
